dm_unit: RTL and testbench

- MEM-stage data memory, directly downstream of the MEM-stage store decoder that produces memwrite.
- Accepts the EX/MEM opcode, address and store data, and commits sw/sh/sb stores with per-byte enables.
- Returns sign- or zero-extended load data for lw/lh/lhu/lb/lbu to the MEM/WB register.
- Flags misaligned accesses and keeps a committed-store counter for the testbench.

---
 rtl/dm_unit_if.sv | 32 +++
 rtl/dm_unit.sv | 159 +++++++++++++++
 tb/tb_dm_unit.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/dm_unit_if.sv
// dm_unit_if: MEM-stage data-memory bus.
// The pipeline side (master) drives the store request, opcode, byte address and
// forwarded store data. The memory (slave) returns extended load data, the lane
// enables of the current access, a misalignment flag and the committed-store count.
//   memwrite  store request from the MEM-stage decoder
//   op        instruction opcode (6 bits)
//   addr      byte address (ALU result)
//   wdata     store data
//   rdata     extended load data
//   be        byte enables, bit i = byte lane i (little-endian)
//   misalign  current load/store is misaligned
//   st_cnt    number of committed stores
interface dm_unit_if;
  logic        memwrite;
  logic [5:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  be;
  logic        misalign;
  logic [31:0] st_cnt;

  modport master (
    output memwrite, op, addr, wdata,
    input  rdata, be, misalign, st_cnt
  );

  modport slave (
    input  memwrite, op, addr, wdata,
    output rdata, be, misalign, st_cnt
  );
endinterface

// File: rtl/dm_unit.sv
// dm_unit: MEM-stage data memory with byte-lane stores and extending loads.
// Stores (sb/sh/sw) commit on the rising clock edge when memwrite is set and the
// access is aligned. Loads (lb/lh/lw/lbu/lhu) read combinationally from the
// current contents, so a load in the same cycle as a store sees the old word.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset; clears every word and the store count
//   bus    dm_unit_if.slave (memwrite, op, addr, wdata in; rdata, be, misalign,
//          st_cnt out)
module dm_unit #(
  parameter int unsigned ADDR_W = 12,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input logic       clk,
  input logic       reset,
  dm_unit_if.slave  bus
);

  localparam int unsigned Depth = 1 << ADDR_W;

  localparam logic [5:0] OpLb  = 6'd32;
  localparam logic [5:0] OpLh  = 6'd33;
  localparam logic [5:0] OpLw  = 6'd35;
  localparam logic [5:0] OpLbu = 6'd36;
  localparam logic [5:0] OpLhu = 6'd37;
  localparam logic [5:0] OpSb  = 6'd40;
  localparam logic [5:0] OpSh  = 6'd41;
  localparam logic [5:0] OpSw  = 6'd43;

  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

  logic              is_load;
  logic              is_store;
  logic              sign_ext;
  size_e             size;
  logic [31:0]       offset;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane;
  logic [3:0]        be_raw;
  logic              misalign_raw;
  logic              misalign;
  logic [3:0]        be;
  logic              commit;
  logic [31:0]       wdata_rep;
  logic [31:0]       be_mask;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       rdata;
  logic [31:0]       st_cnt_q;
  logic [31:0]       mem_rd [Depth];

  // Upper offset bits fall away so addresses wrap modulo the array size.
  assign offset   = bus.addr - BASE;
  assign word_idx = offset[ADDR_W+1:2];
  assign lane     = bus.addr[1:0];

  logic unused_offset;
  assign unused_offset = ^{offset[31:ADDR_W+2], offset[1:0]};

  // Opcode decode.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sign_ext = 1'b0;
    size     = SzWord;
    case (bus.op)
      OpLb:    begin is_load  = 1'b1; size = SzByte; sign_ext = 1'b1; end
      OpLh:    begin is_load  = 1'b1; size = SzHalf; sign_ext = 1'b1; end
      OpLw:    begin is_load  = 1'b1; size = SzWord; end
      OpLbu:   begin is_load  = 1'b1; size = SzByte; end
      OpLhu:   begin is_load  = 1'b1; size = SzHalf; end
      OpSb:    begin is_store = 1'b1; size = SzByte; end
      OpSh:    begin is_store = 1'b1; size = SzHalf; end
      OpSw:    begin is_store = 1'b1; size = SzWord; end
      default: ;
    endcase
  end

  // Lane enables and alignment.
  always_comb begin
    be_raw       = 4'b0000;
    misalign_raw = 1'b0;
    case (size)
      SzWord: begin
        be_raw       = 4'b1111;
        misalign_raw = (lane != 2'b00);
      end
      SzHalf: begin
        be_raw       = lane[1] ? 4'b1100 : 4'b0011;
        misalign_raw = lane[0];
      end
      default: be_raw = 4'b0001 << lane;
    endcase
  end

  assign misalign = (is_load | is_store) & misalign_raw;
  assign be       = ((is_load | is_store) & ~misalign) ? be_raw : 4'b0000;
  assign commit   = bus.memwrite & is_store & ~misalign;

  // Replicate store data so every enabled lane sees the right bytes.
  always_comb begin
    case (size)
      SzByte:  wdata_rep = {4{bus.wdata[7:0]}};
      SzHalf:  wdata_rep = {2{bus.wdata[15:0]}};
      default: wdata_rep = bus.wdata;
    endcase
  end

  assign be_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

  // One register per word so each can be cleared asynchronously in parallel.
  for (genvar i = 0; i < Depth; i++) begin : g_word
    logic [31:0] word_q;
    logic        we;

    assign we = commit && (word_idx == ADDR_W'(i));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        word_q <= 32'h0;
      end else if (we) begin
        word_q <= (word_q & ~be_mask) | (wdata_rep & be_mask);
      end
    end

    assign mem_rd[i] = word_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_cnt_q <= 32'h0;
    end else if (commit) begin
      st_cnt_q <= st_cnt_q + 32'd1;
    end
  end

  // Load path: combinational read of the pre-edge contents.
  assign rd_word = mem_rd[word_idx];
  assign rd_byte = rd_word[{lane, 3'b000} +: 8];
  assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    rdata = 32'h0;
    if (is_load && !misalign) begin
      case (size)
        SzByte:  rdata = sign_ext ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
        SzHalf:  rdata = sign_ext ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
        default: rdata = rd_word;
      endcase
    end
  end

  assign bus.rdata    = rdata;
  assign bus.be       = be;
  assign bus.misalign = misalign;
  assign bus.st_cnt   = st_cnt_q;

endmodule

// File: tb/tb_dm_unit.sv
// tb_dm_unit: directed bench for dm_unit. Inputs change just after the falling
// edge; outputs are sampled 1 time unit later, away from the rising edge.
module tb_dm_unit;

  localparam logic [5:0] OpLb  = 6'd32;
  localparam logic [5:0] OpLh  = 6'd33;
  localparam logic [5:0] OpLw  = 6'd35;
  localparam logic [5:0] OpLbu = 6'd36;
  localparam logic [5:0] OpLhu = 6'd37;
  localparam logic [5:0] OpSb  = 6'd40;
  localparam logic [5:0] OpSh  = 6'd41;
  localparam logic [5:0] OpSw  = 6'd43;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  dm_unit_if bus ();

  dm_unit #(
    .ADDR_W (12),
    .BASE   (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic drv(input logic mw, input logic [5:0] op, input logic [31:0] addr,
                     input logic [31:0] wdata);
    bus.memwrite = mw;
    bus.op       = op;
    bus.addr     = addr;
    bus.wdata    = wdata;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one full cycle: through the rising edge to the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    drv(1'b0, 6'd0, 32'h0, 32'h0);
    #2 reset = 1'b1;
    drv(1'b0, OpLw, 32'h10, 32'h0);
    #1;
    chk("reset_st_cnt", bus.st_cnt, 32'h0);
    chk("reset_rdata", bus.rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Case 1: word store then load back.
    drv(1'b1, OpSw, 32'h10, 32'h8899AABB);
    #1;
    chk("sw_be", {28'h0, bus.be}, 32'hF);
    chk("sw_misalign", {31'h0, bus.misalign}, 32'h0);
    step();
    drv(1'b0, OpLw, 32'h10, 32'h0);
    #1;
    chk("lw_after_sw", bus.rdata, 32'h8899AABB);
    chk("st_cnt_1", bus.st_cnt, 32'd1);

    // Case 2: byte and halfword lane stores.
    @(negedge clk);
    drv(1'b1, OpSb, 32'h11, 32'h000000CC);
    #1 chk("sb_be", {28'h0, bus.be}, 32'h2);
    step();
    drv(1'b0, OpLw, 32'h10, 32'h0);
    #1 chk("word_after_sb", bus.rdata, 32'h8899CCBB);
    @(negedge clk);
    drv(1'b1, OpSh, 32'h12, 32'h0000DDEE);
    #1 chk("sh_be", {28'h0, bus.be}, 32'hC);
    step();
    drv(1'b0, OpLw, 32'h10, 32'h0);
    #1;
    chk("word_after_sh", bus.rdata, 32'hDDEECCBB);
    chk("st_cnt_3", bus.st_cnt, 32'd3);

    // Case 3: extending loads (combinational, no clock needed).
    drv(1'b0, OpLb, 32'h13, 32'h0);
    #1 chk("lb_13", bus.rdata, 32'hFFFFFFDD);
    drv(1'b0, OpLbu, 32'h13, 32'h0);
    #1;
    chk("lbu_13", bus.rdata, 32'h000000DD);
    chk("lbu_13_be", {28'h0, bus.be}, 32'h8);
    drv(1'b0, OpLh, 32'h12, 32'h0);
    #1 chk("lh_12", bus.rdata, 32'hFFFFDDEE);
    drv(1'b0, OpLhu, 32'h10, 32'h0);
    #1 chk("lhu_10", bus.rdata, 32'h0000CCBB);
    drv(1'b0, OpLh, 32'h10, 32'h0);
    #1 chk("lh_10", bus.rdata, 32'hFFFFCCBB);
    drv(1'b0, OpLb, 32'h11, 32'h0);
    #1 chk("lb_11", bus.rdata, 32'hFFFFFFCC);

    // Case 4: misaligned and ignored accesses.
    @(negedge clk);
    drv(1'b1, OpSw, 32'h22, 32'hFFFFFFFF);
    #1;
    chk("sw22_misalign", {31'h0, bus.misalign}, 32'h1);
    chk("sw22_be", {28'h0, bus.be}, 32'h0);
    step();
    drv(1'b0, OpLw, 32'h20, 32'h0);
    #1;
    chk("sw22_no_write", bus.rdata, 32'h0);
    chk("sw22_st_cnt", bus.st_cnt, 32'd3);
    drv(1'b0, OpLh, 32'h11, 32'h0);
    #1;
    chk("lh11_misalign", {31'h0, bus.misalign}, 32'h1);
    chk("lh11_rdata", bus.rdata, 32'h0);
    @(negedge clk);
    drv(1'b1, OpLw, 32'h10, 32'h0);
    step();
    drv(1'b1, OpSw, 32'h10, 32'h11111111);
    bus.memwrite = 1'b0;
    step();
    drv(1'b0, OpLw, 32'h10, 32'h0);
    #1;
    chk("ignored_writes", bus.rdata, 32'hDDEECCBB);
    chk("ignored_st_cnt", bus.st_cnt, 32'd3);
    drv(1'b0, 6'd12, 32'h10, 32'h0);
    #1;
    chk("other_op_rdata", bus.rdata, 32'h0);
    chk("other_op_be", {28'h0, bus.be}, 32'h0);

    // Case 5: read during write sees the old word.
    @(negedge clk);
    drv(1'b0, OpLw, 32'h40, 32'h0);
    #1 chk("rdw_before", bus.rdata, 32'h0);
    drv(1'b1, OpSw, 32'h40, 32'h12345678);
    step();
    drv(1'b0, OpLw, 32'h40, 32'h0);
    #1;
    chk("rdw_after", bus.rdata, 32'h12345678);
    chk("st_cnt_4", bus.st_cnt, 32'd4);

    // Case 6: asynchronous reset mid-cycle.
    drv(1'b0, OpLw, 32'h10, 32'h0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_st_cnt", bus.st_cnt, 32'h0);
    chk("async_rdata", bus.rdata, 32'h0);
    @(negedge clk);
    drv(1'b1, OpSw, 32'h10, 32'hAAAA5555);
    step();
    drv(1'b0, OpLw, 32'h10, 32'h0);
    #1;
    chk("store_in_reset", bus.rdata, 32'h0);
    chk("store_in_reset_cnt", bus.st_cnt, 32'h0);
    reset = 1'b0;

    // First store after reset commits; 0x4010 wraps onto word 4 (0x10).
    @(negedge clk);
    drv(1'b1, OpSw, 32'h4010, 32'hCAFEF00D);
    step();
    drv(1'b0, OpLw, 32'h10, 32'h0);
    #1;
    chk("wrap_store", bus.rdata, 32'hCAFEF00D);
    chk("post_reset_cnt", bus.st_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
